// File: rtl/test_check_pattern_pkg.sv
// Shared constants and state encoding for the MAC test-pattern generator and checker.
// Payload layout: flag, timestamp, zero pad, packet index, then incrementing data bytes.
package test_check_pattern_pkg;

  localparam logic [15:0] ETH_TYPE_TEST = 16'h88B5;
  localparam logic [7:0]  PAT_FLAG      = 8'h07;

  localparam int FLAG_BYTES = 1;
  localparam int TS_BYTES   = 2;
  localparam int ZERO_BYTES = 3;
  localparam int IDX_BYTES  = 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FLAG,
    S_TS,
    S_ZERO,
    S_IDX,
    S_DATA,
    S_DROP
  } state_t;

  // Bit positions match the err_flags status register
  typedef struct packed {
    logic tuser;
    logic len;
    logic data;
    logic zero;
    logic flag;
  } err_t;

  function automatic int seg_bytes(input state_t s);
    case (s)
      S_FLAG:  return FLAG_BYTES;
      S_TS:    return TS_BYTES;
      S_ZERO:  return ZERO_BYTES;
      S_IDX:   return IDX_BYTES;
      default: return 1;
    endcase
  endfunction

  function automatic state_t seg_next(input state_t s);
    case (s)
      S_FLAG:  return S_TS;
      S_TS:    return S_ZERO;
      S_ZERO:  return S_IDX;
      S_IDX:   return S_DATA;
      default: return S_DROP;
    endcase
  endfunction

endpackage

// File: rtl/test_check_pattern_if.sv
// Parsed Ethernet header plus AXI-stream payload, as delivered by the receive frame parser.
// The master drives header/payload; the slave returns the ready signals.
interface test_check_pattern_if;

  logic        s_eth_hdr_valid;
  logic        s_eth_hdr_ready;
  logic [47:0] s_eth_dest_mac;
  logic [47:0] s_eth_src_mac;
  logic [15:0] s_eth_type;
  logic [7:0]  s_eth_payload_axis_tdata;
  logic        s_eth_payload_axis_tvalid;
  logic        s_eth_payload_axis_tready;
  logic        s_eth_payload_axis_tlast;
  logic        s_eth_payload_axis_tuser;

  modport master (
    output s_eth_hdr_valid, s_eth_dest_mac, s_eth_src_mac, s_eth_type,
           s_eth_payload_axis_tdata, s_eth_payload_axis_tvalid,
           s_eth_payload_axis_tlast, s_eth_payload_axis_tuser,
    input  s_eth_hdr_ready, s_eth_payload_axis_tready
  );

  modport slave (
    input  s_eth_hdr_valid, s_eth_dest_mac, s_eth_src_mac, s_eth_type,
           s_eth_payload_axis_tdata, s_eth_payload_axis_tvalid,
           s_eth_payload_axis_tlast, s_eth_payload_axis_tuser,
    output s_eth_hdr_ready, s_eth_payload_axis_tready
  );

endinterface

// File: rtl/test_check_pattern_sat_counter.sv
// Saturating accumulator: adds inc when en, sticks at all-ones, synchronous clear has priority.
// Result visible one cycle after en; no handshake.
module test_check_pattern_sat_counter #(
  parameter int WIDTH     = 32,
  parameter int INC_WIDTH = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clear,
  input  logic                 en,
  input  logic [INC_WIDTH-1:0] inc,
  output logic [WIDTH-1:0]     count
);

  logic [WIDTH:0] sum;

  assign sum = {1'b0, count} + {{(WIDTH + 1 - INC_WIDTH){1'b0}}, inc};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (en) begin
      count <= sum[WIDTH] ? '1 : sum[WIDTH-1:0];
    end
  end

endmodule

// File: rtl/test_check_pattern.sv
// Receive-side checker for test-pattern frames; status updates one cycle after the tlast byte.
// Never backpressures payload; header is accepted only while idle.
module test_check_pattern
  import test_check_pattern_pkg::*;
#(
  parameter int DATA_LENGTH = 64,
  parameter int DATA_WIDTH  = 8,
  parameter int CNT_WIDTH   = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clear,
  test_check_pattern_if.slave  eth,
  input  logic [47:0]          local_mac,
  output logic [CNT_WIDTH-1:0] frame_count,
  output logic [CNT_WIDTH-1:0] good_count,
  output logic [CNT_WIDTH-1:0] error_count,
  output logic [CNT_WIDTH-1:0] lost_count,
  output logic [CNT_WIDTH-1:0] foreign_count,
  output logic [15:0]          last_timestamp,
  output logic [15:0]          last_packet_index,
  output logic [4:0]           err_flags,
  output logic                 frame_done,
  output logic                 frame_ok
);

  logic [1:0]            rst_sync;
  logic                  rst_n_sync;
  state_t                state, state_nxt;
  logic [15:0]           cnt, cnt_nxt;
  logic                  acc;
  err_t                  err, err_nxt, byte_err;
  logic [15:0]           ts, ts_nxt, idx, idx_nxt, gap;
  logic                  idx_full, idx_full_nxt;
  logic [7:0]            last_dat, exp_dat;
  logic                  hist_vld;
  logic                  hdr_xfer, pay_xfer, hdr_match;
  logic                  done, ok, foreign_inc, lost_en;
  logic [DATA_WIDTH-1:0] dat;
  logic                  unused_src;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync <= '0;
    else        rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_n_sync = rst_sync[1];

  assign unused_src = ^eth.s_eth_src_mac;
  assign dat        = eth.s_eth_payload_axis_tdata;
  assign eth.s_eth_hdr_ready           = (state == S_IDLE);
  assign eth.s_eth_payload_axis_tready = (state != S_IDLE);
  assign hdr_xfer  = eth.s_eth_hdr_valid & eth.s_eth_hdr_ready;
  assign pay_xfer  = eth.s_eth_payload_axis_tvalid & eth.s_eth_payload_axis_tready;
  assign hdr_match = (eth.s_eth_type == ETH_TYPE_TEST) &&
                     ((eth.s_eth_dest_mac == local_mac) || (eth.s_eth_dest_mac == '1));
  assign exp_dat   = last_dat + 8'd1;

  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    byte_err     = '0;
    done         = 1'b0;
    foreign_inc  = 1'b0;
    ts_nxt       = ts;
    idx_nxt      = idx;
    idx_full_nxt = idx_full;
    case (state)
      S_IDLE: begin
        if (hdr_xfer) begin
          state_nxt   = hdr_match ? S_FLAG : S_DROP;
          foreign_inc = ~hdr_match;
        end
      end
      S_DROP: begin
        if (pay_xfer && eth.s_eth_payload_axis_tlast) begin
          state_nxt = S_IDLE;
          done      = acc;
        end
      end
      default: begin
        if (pay_xfer) begin
          case (state)
            S_FLAG: byte_err.flag = (dat != PAT_FLAG);
            S_TS: begin
              if (cnt[0]) ts_nxt[15:8] = dat;
              else        ts_nxt[7:0]  = dat;
            end
            S_ZERO: byte_err.zero = (dat != '0);
            S_IDX: begin
              if (cnt[0]) begin
                idx_nxt[15:8] = dat;
                idx_full_nxt  = 1'b1;
              end else begin
                idx_nxt[7:0] = dat;
              end
            end
            S_DATA: begin
              // First byte only chains to the previous frame when the index is consecutive
              if (cnt != '0 || (hist_vld && idx == last_packet_index + 16'd1))
                byte_err.data = (dat != exp_dat);
            end
            default: ;
          endcase

          if (state == S_DATA && cnt == 16'(DATA_LENGTH - 1)) begin
            if (eth.s_eth_payload_axis_tlast) begin
              done      = 1'b1;
              state_nxt = S_IDLE;
            end else begin
              byte_err.len = 1'b1;
              state_nxt    = S_DROP;
            end
          end else if (eth.s_eth_payload_axis_tlast) begin
            byte_err.len = 1'b1;
            done         = 1'b1;
            state_nxt    = S_IDLE;
          end else if (state != S_DATA && cnt == 16'(seg_bytes(state) - 1)) begin
            state_nxt = seg_next(state);
          end else begin
            cnt_nxt = cnt + 16'd1;
          end
        end
      end
    endcase
    if (done) byte_err.tuser = eth.s_eth_payload_axis_tuser;
    err_nxt = err | byte_err;
  end

  assign ok      = ~(|err_nxt);
  assign gap     = idx_nxt - last_packet_index - 16'd1;
  assign lost_en = done && idx_full_nxt && hist_vld &&
                   (idx_nxt != last_packet_index + 16'd1) && (idx_nxt != last_packet_index);

  always_ff @(posedge clk or negedge rst_n_sync) begin
    if (!rst_n_sync) begin
      state             <= S_IDLE;
      cnt               <= '0;
      acc               <= 1'b0;
      err               <= '0;
      ts                <= '0;
      idx               <= '0;
      idx_full          <= 1'b0;
      last_dat          <= '0;
      hist_vld          <= 1'b0;
      last_timestamp    <= '0;
      last_packet_index <= '0;
      err_flags         <= '0;
      frame_done        <= 1'b0;
      frame_ok          <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= (state_nxt != state) ? '0 : cnt_nxt;
      if (hdr_xfer) begin
        acc      <= hdr_match;
        err      <= '0;
        ts       <= '0;
        idx      <= '0;
        idx_full <= 1'b0;
      end else begin
        err      <= err_nxt;
        ts       <= ts_nxt;
        idx      <= idx_nxt;
        idx_full <= idx_full_nxt;
      end
      if (pay_xfer && state == S_DATA) last_dat <= dat;
      frame_done <= done & ~clear;
      frame_ok   <= done & ~clear & ok;
      if (clear) begin
        hist_vld  <= 1'b0;
        err_flags <= '0;
      end else begin
        err_flags <= err_flags | byte_err;
        if (done) begin
          last_timestamp <= ts_nxt;
          if (idx_full_nxt) begin
            last_packet_index <= idx_nxt;
            hist_vld          <= 1'b1;
          end
        end
      end
    end
  end

  test_check_pattern_sat_counter #(.WIDTH(CNT_WIDTH), .INC_WIDTH(1)) u_frame_cnt (
    .clk(clk), .rst_n(rst_n_sync), .clear(clear), .en(done), .inc(1'b1), .count(frame_count));
  test_check_pattern_sat_counter #(.WIDTH(CNT_WIDTH), .INC_WIDTH(1)) u_good_cnt (
    .clk(clk), .rst_n(rst_n_sync), .clear(clear), .en(done & ok), .inc(1'b1), .count(good_count));
  test_check_pattern_sat_counter #(.WIDTH(CNT_WIDTH), .INC_WIDTH(1)) u_error_cnt (
    .clk(clk), .rst_n(rst_n_sync), .clear(clear), .en(done & ~ok), .inc(1'b1), .count(error_count));
  test_check_pattern_sat_counter #(.WIDTH(CNT_WIDTH), .INC_WIDTH(16)) u_lost_cnt (
    .clk(clk), .rst_n(rst_n_sync), .clear(clear), .en(lost_en), .inc(gap), .count(lost_count));
  test_check_pattern_sat_counter #(.WIDTH(CNT_WIDTH), .INC_WIDTH(1)) u_foreign_cnt (
    .clk(clk), .rst_n(rst_n_sync), .clear(clear), .en(foreign_inc), .inc(1'b1), .count(foreign_count));

endmodule
